btb_update_queue: RTL and testbench
===================================

# btb_update_queue

Buffers resolved-branch BTB update requests from the backend and issues them, one per cycle, onto the BTB's two-stage update port. Update 0 carries valid, start PC and ASID. Update 1 carries pred info, pred LRU and target on the following cycle. The block sits between branch resolution and the BTB, absorbing bursts of resolutions, since the BTB update port has no backpressure.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of 2, ≥2
- LOG_DEPTH, $clog2(DEPTH), pointer index width

Ports (widths ASID_WIDTH, BTB_PRED_INFO_WIDTH from core_types_pkg):
- CLK  in  1  clock, all state on posedge
- nRST  in  1  reset, asynchronous, active-low
- enq_valid  in  1  update request present
- enq_ready  out  1  queue accepts this cycle
- enq_start_full_PC  in  32  fetch-block start PC of branch
- enq_ASID  in  ASID_WIDTH  address space ID
- enq_pred_info  in  BTB_PRED_INFO_WIDTH  new pred info
- enq_pred_lru  in  1  way being written
- enq_target_full_PC  in  32  branch target
- hold  in  1  suppress issue (BTB busy/init); queue keeps filling
- flush  in  1  discard all queued entries
- update0_valid  out  1  update 0 valid to BTB
- update0_start_full_PC  out  32  update 0 PC
- update0_ASID  out  ASID_WIDTH  update 0 ASID
- update1_pred_info  out  BTB_PRED_INFO_WIDTH  update 1 pred info
- update1_pred_lru  out  1  update 1 LRU/way
- update1_target_full_PC  out  32  update 1 target
- occupancy  out  LOG_DEPTH+1  queued entry count

## Operation
- Circular buffer, DEPTH entries. Each entry holds {start PC, ASID, pred_info, pred_lru, target PC}.
- head/tail pointers are LOG_DEPTH+1 bits; the MSB is the wrap bit. empty = (head==tail). full = index equal and wrap bits differ.
- enq_ready = ~full & ~flush. Full means no accept, even if issue frees a slot the same cycle.
- Enqueue: enq_valid & enq_ready writes at tail, tail++.
- Issue condition: ~empty & ~hold & ~flush.
- update0_valid = issue condition. update0_start_full_PC/ASID are driven combinationally from the head entry.
- On issue:
  - head++.
  - pred_info, pred_lru and target of the head entry are registered into the update1_* outputs.
- update1_* registers load only on issue. Otherwise they hold their value.
- Flush:
  - head and tail set equal next cycle, occupancy 0.
  - A same-cycle enq is dropped (enq_ready low).
  - No update0 is issued in the flush cycle.
  - An entry issued the previous cycle keeps its update1 fields valid this cycle; flush never disturbs update1 regs.
- Simultaneous enq and issue with non-empty, non-full queue: occupancy unchanged. The entry enqueued this cycle is not visible at head until the next cycle.
- Wrap-around: the index wraps modulo DEPTH and the wrap bit toggles. Ordering is strictly FIFO.
- occupancy = tail − head (mod 2^(LOG_DEPTH+1)).

## Timing
- Reset values:
  - head = tail = 0, occupancy 0, enq_ready 1, update0_valid 0.
  - update0_start_full_PC and update0_ASID are 0 (head entry storage resets to 0).
  - update1_pred_info 0, update1_pred_lru 0, update1_target_full_PC 0.
- Latency, enq to update0: 1 cycle minimum (enq in cycle N, issue in N+1 if not held).
- The update1 fields for the update0 issued in cycle N are valid in cycle N+1. This matches the BTB's update0→update1 register stage.
- Throughput: 1 update per cycle sustained.
- Reset mid-operation: all queued entries are lost. Outputs return to reset values asynchronously.

## Configuration
- BTB_UPDATE_QUEUE_BYPASS_EN defined:
  - When empty & enq_valid & ~hold & ~flush, update0 is driven combinationally from the enq_* inputs in the same cycle. update0_valid=1.
  - update1 regs capture enq_pred_info, enq_pred_lru and enq_target_full_PC. Nothing is written to the queue; occupancy stays 0.
  - Zero-cycle latency.
- Not defined: no bypass. Empty-queue enqueues always take the 1-cycle path.

## Test plan
- Reset, then enq 1 entry (PC 0x1000, ASID 3, target 0x2000, lru 1):
  - No bypass: update0_valid=1 with PC 0x1000 in the next cycle; update1_target_full_PC=0x2000 and lru=1 the cycle after.
  - Bypass: update0_valid=1 in the enq cycle.
- hold=1, enqueue DEPTH entries: enq_ready=0 and occupancy=DEPTH; an extra enq is not accepted. Release hold: DEPTH back-to-back update0s in FIFO order, PCs matching enq order.
- Continuous enq+issue for 3×DEPTH entries with wrap: every PC is issued exactly once, in order; occupancy never exceeds 1 (non-bypass).
- Queue holding 3 entries, flush=1: update0_valid=0 that cycle; occupancy=0 next cycle; no further update0. The previous cycle's update1 fields remain intact.
- flush and enq_valid asserted together: enq_ready=0 and the entry is dropped; occupancy=0 afterwards.
- nRST asserted with 2 entries queued: occupancy=0 and all update1_* outputs 0 immediately; no update0 after release until a new enq.

Source files
------------

// File: rtl/btb_update_queue_if.sv
// Handshake bundle between branch resolution, btb_update_queue and the BTB update port.
// The slave modport is the queue's own view; the master modport is the surrounding logic.
interface btb_update_queue_if #(
    parameter int LOG_DEPTH           = 2,
    parameter int ASID_WIDTH          = 9,
    parameter int BTB_PRED_INFO_WIDTH = 8
);
    logic                           enq_valid;
    logic                           enq_ready;
    logic [31:0]                    enq_start_full_PC;
    logic [ASID_WIDTH-1:0]          enq_ASID;
    logic [BTB_PRED_INFO_WIDTH-1:0] enq_pred_info;
    logic                           enq_pred_lru;
    logic [31:0]                    enq_target_full_PC;
    logic                           hold;
    logic                           flush;
    logic                           update0_valid;
    logic [31:0]                    update0_start_full_PC;
    logic [ASID_WIDTH-1:0]          update0_ASID;
    logic [BTB_PRED_INFO_WIDTH-1:0] update1_pred_info;
    logic                           update1_pred_lru;
    logic [31:0]                    update1_target_full_PC;
    logic [LOG_DEPTH:0]             occupancy;

    modport slave (
        input  enq_valid, enq_start_full_PC, enq_ASID, enq_pred_info, enq_pred_lru,
               enq_target_full_PC, hold, flush,
        output enq_ready, update0_valid, update0_start_full_PC, update0_ASID,
               update1_pred_info, update1_pred_lru, update1_target_full_PC, occupancy
    );

    modport master (
        output enq_valid, enq_start_full_PC, enq_ASID, enq_pred_info, enq_pred_lru,
               enq_target_full_PC, hold, flush,
        input  enq_ready, update0_valid, update0_start_full_PC, update0_ASID,
               update1_pred_info, update1_pred_lru, update1_target_full_PC, occupancy
    );
endinterface

// File: rtl/btb_update_queue.sv
// FIFO of resolved-branch BTB updates feeding the BTB's two-stage update port, one per cycle.
// Optional BTB_UPDATE_QUEUE_BYPASS_EN: empty-queue enqueues issue in the same cycle.
module btb_update_queue #(
    parameter int DEPTH               = 4,
    parameter int LOG_DEPTH           = $clog2(DEPTH),
    parameter int ASID_WIDTH          = 9,
    parameter int BTB_PRED_INFO_WIDTH = 8
) (
    input  logic CLK,
    input  logic nRST,
    btb_update_queue_if.slave q
);
    logic [31:0]                    pc_q   [DEPTH];
    logic [ASID_WIDTH-1:0]          asid_q [DEPTH];
    logic [BTB_PRED_INFO_WIDTH-1:0] info_q [DEPTH];
    logic                           lru_q  [DEPTH];
    logic [31:0]                    tgt_q  [DEPTH];

    logic [LOG_DEPTH:0] head_q, head_d;
    logic [LOG_DEPTH:0] tail_q, tail_d;

    logic [BTB_PRED_INFO_WIDTH-1:0] upd1_info_q, upd1_info_d;
    logic                           upd1_lru_q,  upd1_lru_d;
    logic [31:0]                    upd1_tgt_q,  upd1_tgt_d;

    logic [LOG_DEPTH-1:0] head_idx, tail_idx;
    logic empty, full, issue, bypass, do_enq;

    assign head_idx = head_q[LOG_DEPTH-1:0];
    assign tail_idx = tail_q[LOG_DEPTH-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[LOG_DEPTH] != tail_q[LOG_DEPTH]);

    // Full blocks enqueue even if an issue frees a slot this cycle.
    assign q.enq_ready = ~full & ~q.flush;
    assign issue       = ~empty & ~q.hold & ~q.flush;

`ifdef BTB_UPDATE_QUEUE_BYPASS_EN
    assign bypass = empty & q.enq_valid & ~q.hold & ~q.flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed request goes straight to the BTB and never occupies a slot.
    assign do_enq = q.enq_valid & q.enq_ready & ~bypass;

    assign q.update0_valid         = issue | bypass;
    assign q.update0_start_full_PC = bypass ? q.enq_start_full_PC : pc_q[head_idx];
    assign q.update0_ASID          = bypass ? q.enq_ASID          : asid_q[head_idx];
    assign q.occupancy             = tail_q - head_q;

    assign q.update1_pred_info      = upd1_info_q;
    assign q.update1_pred_lru       = upd1_lru_q;
    assign q.update1_target_full_PC = upd1_tgt_q;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        upd1_info_d = upd1_info_q;
        upd1_lru_d  = upd1_lru_q;
        upd1_tgt_d  = upd1_tgt_q;
        if (q.flush) begin
            head_d = tail_q;
        end else begin
            if (issue)  head_d = head_q + 1'b1;
            if (do_enq) tail_d = tail_q + 1'b1;
        end
        if (bypass) begin
            upd1_info_d = q.enq_pred_info;
            upd1_lru_d  = q.enq_pred_lru;
            upd1_tgt_d  = q.enq_target_full_PC;
        end else if (issue) begin
            upd1_info_d = info_q[head_idx];
            upd1_lru_d  = lru_q[head_idx];
            upd1_tgt_d  = tgt_q[head_idx];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q      <= '0;
            tail_q      <= '0;
            upd1_info_q <= '0;
            upd1_lru_q  <= 1'b0;
            upd1_tgt_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            upd1_info_q <= upd1_info_d;
            upd1_lru_q  <= upd1_lru_d;
            upd1_tgt_q  <= upd1_tgt_d;
        end
    end

    // Storage is reset so the idle head entry reads back as zero.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                asid_q[i] <= '0;
                info_q[i] <= '0;
                lru_q[i]  <= 1'b0;
                tgt_q[i]  <= '0;
            end
        end else if (do_enq) begin
            pc_q[tail_idx]   <= q.enq_start_full_PC;
            asid_q[tail_idx] <= q.enq_ASID;
            info_q[tail_idx] <= q.enq_pred_info;
            lru_q[tail_idx]  <= q.enq_pred_lru;
            tgt_q[tail_idx]  <= q.enq_target_full_PC;
        end
    end
endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue in its default (no bypass) build.
module tb_btb_update_queue;
    localparam int DEPTH = 4;
    localparam int LOGD  = 2;
    localparam int AW    = 9;
    localparam int PW    = 8;

    logic CLK = 1'b0;
    logic nRST;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    btb_update_queue_if #(.LOG_DEPTH(LOGD), .ASID_WIDTH(AW), .BTB_PRED_INFO_WIDTH(PW)) bus ();

    btb_update_queue #(
        .DEPTH(DEPTH), .LOG_DEPTH(LOGD), .ASID_WIDTH(AW), .BTB_PRED_INFO_WIDTH(PW)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .q(bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_enq(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic lru, input logic [7:0] info, input logic [8:0] asid);
        bus.enq_valid          = v;
        bus.enq_start_full_PC  = pc;
        bus.enq_target_full_PC = tgt;
        bus.enq_pred_lru       = lru;
        bus.enq_pred_info      = info;
        bus.enq_ASID           = asid;
    endtask

    initial begin
        nRST      = 1'b0;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 9'h0);
        #12;
        check("rst_occ", 32'(bus.occupancy), 32'd0);
        check("rst_ready", 32'(bus.enq_ready), 32'd1);
        check("rst_u0v", 32'(bus.update0_valid), 32'd0);
        check("rst_u0pc", bus.update0_start_full_PC, 32'h0);
        check("rst_u0asid", 32'(bus.update0_ASID), 32'd0);
        check("rst_u1tgt", bus.update1_target_full_PC, 32'h0);
        check("rst_u1info", 32'(bus.update1_pred_info), 32'd0);
        check("rst_u1lru", 32'(bus.update1_pred_lru), 32'd0);
        nRST = 1'b1;
        tick();

        // Single entry: issue one cycle after enqueue, update1 one cycle later.
        set_enq(1'b1, 32'h1000, 32'h2000, 1'b1, 8'h5A, 9'd3);
        #1;
        check("one_enq_u0v", 32'(bus.update0_valid), 32'd0);
        tick();
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 9'h0);
        #1;
        check("one_u0v", 32'(bus.update0_valid), 32'd1);
        check("one_u0pc", bus.update0_start_full_PC, 32'h1000);
        check("one_u0asid", 32'(bus.update0_ASID), 32'd3);
        check("one_occ", 32'(bus.occupancy), 32'd1);
        tick();
        check("one_u1tgt", bus.update1_target_full_PC, 32'h2000);
        check("one_u1lru", 32'(bus.update1_pred_lru), 32'd1);
        check("one_u1info", 32'(bus.update1_pred_info), 32'h5A);
        check("one_after_u0v", 32'(bus.update0_valid), 32'd0);
        check("one_after_occ", 32'(bus.occupancy), 32'd0);

        // Fill under hold, refuse extra, then drain in FIFO order.
        bus.hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_enq(1'b1, 32'h100 + 32'(i * 4), 32'h8100 + 32'(i * 4), 1'(i), 8'(i), 9'(i));
            #1;
            check("fill_ready", 32'(bus.enq_ready), 32'd1);
            tick();
        end
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 9'h0);
        #1;
        check("full_occ", 32'(bus.occupancy), 32'd4);
        check("full_ready", 32'(bus.enq_ready), 32'd0);
        check("full_hold_u0v", 32'(bus.update0_valid), 32'd0);
        set_enq(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 8'h0, 9'h0);
        tick();
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 9'h0);
        #1;
        check("full_extra_occ", 32'(bus.occupancy), 32'd4);
        bus.hold = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("drain_u0v", 32'(bus.update0_valid), 32'd1);
            check("drain_u0pc", bus.update0_start_full_PC, 32'h100 + 32'(i * 4));
            tick();
            check("drain_u1tgt", bus.update1_target_full_PC, 32'h8100 + 32'(i * 4));
        end
        check("drain_occ", 32'(bus.occupancy), 32'd0);
        check("drain_u0v_end", 32'(bus.update0_valid), 32'd0);

        // Continuous enqueue+issue across several wraps.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            set_enq(1'b1, 32'h4000 + 32'(i), 32'hC000 + 32'(i), 1'b0, 8'h0, 9'h0);
            #1;
            if (i == 0) begin
                check("stream_u0v0", 32'(bus.update0_valid), 32'd0);
                check("stream_occ0", 32'(bus.occupancy), 32'd0);
            end else begin
                check("stream_u0v", 32'(bus.update0_valid), 32'd1);
                check("stream_u0pc", bus.update0_start_full_PC, 32'h4000 + 32'(i - 1));
                check("stream_occ", 32'(bus.occupancy), 32'd1);
            end
            tick();
        end
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 9'h0);
        #1;
        check("stream_last_pc", bus.update0_start_full_PC, 32'h400B);
        tick();
        check("stream_end_occ", 32'(bus.occupancy), 32'd0);
        check("stream_end_u1tgt", bus.update1_target_full_PC, 32'hC00B);

        // Flush with 3 entries queued and a same-cycle enqueue.
        bus.hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_enq(1'b1, 32'h6000 + 32'(i), 32'hE000 + 32'(i), 1'b1, 8'h33, 9'h0);
            tick();
        end
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 9'h0);
        bus.hold = 1'b0;
        #1;
        check("pre_flush_pc", bus.update0_start_full_PC, 32'h6000);
        tick();
        bus.flush = 1'b1;
        set_enq(1'b1, 32'hBEEF, 32'hF00D, 1'b0, 8'h0, 9'h0);
        #1;
        check("flush_u0v", 32'(bus.update0_valid), 32'd0);
        check("flush_ready", 32'(bus.enq_ready), 32'd0);
        check("flush_occ_before", 32'(bus.occupancy), 32'd3);
        check("flush_u1tgt", bus.update1_target_full_PC, 32'hE000);
        tick();
        bus.flush = 1'b0;
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 9'h0);
        #1;
        check("post_flush_occ", 32'(bus.occupancy), 32'd0);
        check("post_flush_u0v", 32'(bus.update0_valid), 32'd0);
        check("post_flush_u1tgt", bus.update1_target_full_PC, 32'hE000);
        check("post_flush_u1lru", 32'(bus.update1_pred_lru), 32'd1);
        tick();
        check("post_flush_u0v2", 32'(bus.update0_valid), 32'd0);

        // Asynchronous reset with two entries queued.
        bus.hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_enq(1'b1, 32'h7000 + 32'(i), 32'h9000 + 32'(i), 1'b1, 8'h77, 9'd5);
            tick();
        end
        set_enq(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 9'h0);
        #1;
        check("prerst_occ", 32'(bus.occupancy), 32'd2);
        nRST = 1'b0;
        #1;
        check("arst_occ", 32'(bus.occupancy), 32'd0);
        check("arst_u1tgt", bus.update1_target_full_PC, 32'h0);
        check("arst_u1lru", 32'(bus.update1_pred_lru), 32'd0);
        check("arst_u1info", 32'(bus.update1_pred_info), 32'd0);
        check("arst_u0pc", bus.update0_start_full_PC, 32'h0);
        #3;
        nRST = 1'b1;
        bus.hold = 1'b0;
        #1;
        check("rel_u0v", 32'(bus.update0_valid), 32'd0);
        tick();
        check("rel_u0v2", 32'(bus.update0_valid), 32'd0);
        check("rel_occ", 32'(bus.occupancy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
